// File: rtl/if_id_stage_buffer_pkg.sv
// pipeline_pkg: word width, NOP encoding, PC step and the buffered entry type shared by fetch and decode
package pipeline_pkg;
  localparam int WORD_WIDTH = 32;
  typedef logic [WORD_WIDTH-1:0] word_t;
  localparam word_t MIPS_NOP = 32'h0000_0000;
  localparam word_t PC_INCREMENT = 32'd4;
  typedef struct packed {
    word_t instruction;
    word_t program_counter;
  } entry_t;
endpackage

// File: rtl/if_id_stage_buffer_if.sv
// if_id_stage_buffer_if: fetch-side and decode-side handshake bundle; slave is the buffer
interface if_id_stage_buffer_if;
  import pipeline_pkg::*;
  word_t fetch_instruction;
  word_t fetch_program_counter;
  logic fetch_valid;
  logic fetch_ready;
  logic flush;
  word_t decode_instruction;
  word_t decode_program_counter;
  word_t decode_pc_plus_4;
  logic decode_valid;
  logic decode_ready;
  modport slave (
    input fetch_instruction, fetch_program_counter, fetch_valid, flush, decode_ready,
    output fetch_ready, decode_instruction, decode_program_counter, decode_pc_plus_4, decode_valid
  );
  modport master (
    output fetch_instruction, fetch_program_counter, fetch_valid, flush, decode_ready,
    input fetch_ready, decode_instruction, decode_program_counter, decode_pc_plus_4, decode_valid
  );
endinterface

// File: rtl/if_id_stage_buffer_fifo_storage.sv
// if_id_fifo_storage: entry register array written on push with a combinational head read
module if_id_fifo_storage
  import pipeline_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int PTR_WIDTH = $clog2(DEPTH)
) (
  input  logic                 system_clock,
  input  logic                 write_enable,
  input  logic [PTR_WIDTH-1:0] write_pointer,
  input  entry_t               write_entry,
  input  logic [PTR_WIDTH-1:0] read_pointer,
  output entry_t               head_entry
);
  entry_t mem [DEPTH];
  always_ff @(posedge system_clock)
    if (write_enable) mem[write_pointer] <= write_entry;
  assign head_entry = mem[read_pointer];
endmodule

// File: rtl/if_id_stage_buffer.sv
// if_id_stage_buffer: IF/ID FIFO with flush and NOP-when-empty; define IF_ID_STALL_COUNT_EN for stall_cycle_count
module if_id_stage_buffer
  import pipeline_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                  system_clock,
  input  logic                  reset,
  if_id_stage_buffer_if.slave   bus
`ifdef IF_ID_STALL_COUNT_EN
  ,
  output logic [WORD_WIDTH-1:0] stall_cycle_count
`endif
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL = (PW+1)'(DEPTH);
  logic [PW-1:0] write_pointer, read_pointer;
  logic [PW:0] count;
  logic push, pop;
  entry_t head;
  assign bus.fetch_ready = count != FULL;
  assign bus.decode_valid = count != '0;
  assign push = bus.fetch_valid & bus.fetch_ready & ~bus.flush;
  assign pop = bus.decode_valid & bus.decode_ready & ~bus.flush;
  always_ff @(posedge system_clock) begin
    if (reset || bus.flush) begin
      write_pointer <= '0;
      read_pointer <= '0;
      count <= '0;
    end else begin
      if (push) write_pointer <= write_pointer + 1'b1;
      if (pop) read_pointer <= read_pointer + 1'b1;
      count <= count + (PW+1)'(push) - (PW+1)'(pop);
    end
  end
  if_id_fifo_storage #(.DEPTH(DEPTH), .PTR_WIDTH(PW)) storage (
    .system_clock (system_clock),
    .write_enable (push),
    .write_pointer(write_pointer),
    .write_entry  ({bus.fetch_instruction, bus.fetch_program_counter}),
    .read_pointer (read_pointer),
    .head_entry   (head)
  );
  assign bus.decode_instruction = bus.decode_valid ? head.instruction : MIPS_NOP;
  assign bus.decode_program_counter = bus.decode_valid ? head.program_counter : MIPS_NOP;
  assign bus.decode_pc_plus_4 = bus.decode_valid ? head.program_counter + PC_INCREMENT : MIPS_NOP;
`ifdef IF_ID_STALL_COUNT_EN
  always_ff @(posedge system_clock) begin
    if (reset) stall_cycle_count <= '0;
    else if (bus.decode_valid && !bus.decode_ready && !bus.flush && stall_cycle_count != '1)
      stall_cycle_count <= stall_cycle_count + 1'b1;
  end
`endif
endmodule
